// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared types and widths for the two-port global memory arbiter.
//   MEM_ADDR_W / MEM_DATA_W / MEM_BYTES_W : global memory bus widths
//   STARVE_LIMIT_DEFAULT                  : default urgent-grant budget for r0
//   arb_state_t                           : arbiter FSM state encoding
//   mem_req_t                             : latched memory request payload
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    localparam int unsigned MEM_ADDR_W           = 27;
    localparam int unsigned MEM_DATA_W           = 128;
    localparam int unsigned MEM_BYTES_W          = 8;
    localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0]  addr;
        logic                   we;
        logic [MEM_BYTES_W-1:0] bytes;
        logic [MEM_DATA_W-1:0]  wdata;
    } mem_req_t;

    // Starvation counter width; a zero limit still needs one bit to compare against.
    function automatic int unsigned starve_cnt_w(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/rr_grant2.sv
// -----------------------------------------------------------------------------
// rr_grant2
// Combinational 2-way arbiter for the memory port.
//   valid0, valid1 : request present from requester 0 / 1
//   urgent         : requester 0 is valid and urgent
//   starved        : requester 1 has waited through the urgent-grant budget
//   lastGrant      : requester that won the previous arbitration
//   anyValid       : at least one request is present
//   winner         : selected requester (0 or 1), meaningful when anyValid
// -----------------------------------------------------------------------------
module rr_grant2 (
    input  logic valid0,
    input  logic valid1,
    input  logic urgent,
    input  logic starved,
    input  logic lastGrant,
    output logic anyValid,
    output logic winner
);

    // Urgent r0 pre-empts unless r1 is starved; a starved r1 falls back to
    // round-robin, which it wins because the budget was spent on r0 grants.
    always_comb begin
        anyValid = valid0 | valid1;
        winner   = 1'b0;
        if (urgent && !starved) begin
            winner = 1'b0;
        end else if (valid0 && valid1) begin
            winner = ~lastGrant;
        end else if (valid1) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one global memory port between a scanout reader (r0) and a GPU cache
// (r1). One transaction at a time: IDLE -> BUSY (memEnable held) -> DONE
// (one-cycle done pulse to the owner) -> IDLE.
//   clk, reset                     : clock, asynchronous active-high reset
//   r0Valid/r0Urgent/r0Addr        : scanout read request
//   r0Done                         : completion pulse for requester 0
//   r1Valid/r1Addr/r1Write/
//   r1WData/r1Bytes                : GPU cache read/write request
//   r1Done                         : completion pulse for requester 1
//   rdData                         : read data, valid with the done pulse
//   memAddr/memWriteData/memEnable/
//   memWriteEnable/memWriteBytes   : global memory request
//   memReadData/memFinishedAction  : global memory response
//   grantId                        : owner of current / most recent transaction
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   r0Valid,
    input  logic                   r0Urgent,
    input  logic [MEM_ADDR_W-1:0]  r0Addr,
    output logic                   r0Done,

    input  logic                   r1Valid,
    input  logic [MEM_ADDR_W-1:0]  r1Addr,
    input  logic                   r1Write,
    input  logic [MEM_DATA_W-1:0]  r1WData,
    input  logic [MEM_BYTES_W-1:0] r1Bytes,
    output logic                   r1Done,

    output logic [MEM_DATA_W-1:0]  rdData,

    output logic [MEM_ADDR_W-1:0]  memAddr,
    output logic [MEM_DATA_W-1:0]  memWriteData,
    output logic                   memEnable,
    output logic                   memWriteEnable,
    output logic [MEM_BYTES_W-1:0] memWriteBytes,
    input  logic [MEM_DATA_W-1:0]  memReadData,
    input  logic                   memFinishedAction,

    output logic                   grantId
);

    localparam int unsigned CNT_W = starve_cnt_w(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t       state;
    logic [CNT_W-1:0] starve_cnt;
    mem_req_t         req_q;

    logic     urgent_c;
    logic     starved_c;
    logic     any_valid_c;
    logic     winner_c;
    mem_req_t r0_req_c;
    mem_req_t r1_req_c;

    assign urgent_c  = r0Valid & r0Urgent;
    assign starved_c = (starve_cnt == CNT_MAX) & r1Valid;

    // Scanout is read-only, so its write fields are forced to zero.
    always_comb begin
        r0_req_c       = '0;
        r0_req_c.addr  = r0Addr;
        r1_req_c       = '0;
        r1_req_c.addr  = r1Addr;
        r1_req_c.we    = r1Write;
        r1_req_c.bytes = r1Bytes;
        r1_req_c.wdata = r1WData;
    end

    rr_grant2 u_rr_grant2 (
        .valid0    (r0Valid),
        .valid1    (r1Valid),
        .urgent    (urgent_c),
        .starved   (starved_c),
        .lastGrant (grantId),
        .anyValid  (any_valid_c),
        .winner    (winner_c)
    );

    // Memory request outputs come straight from the latched request register.
    assign memAddr        = req_q.addr;
    assign memWriteEnable = req_q.we;
    assign memWriteBytes  = req_q.bytes;
    assign memWriteData   = req_q.wdata;

    // FSM, request latch, starvation counter and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            req_q      <= '0;
            memEnable  <= 1'b0;
            rdData     <= '0;
            r0Done     <= 1'b0;
            r1Done     <= 1'b0;
            grantId    <= 1'b1;
            starve_cnt <= '0;
        end else begin
            r0Done <= 1'b0;
            r1Done <= 1'b0;

            // The budget only matters while r1 is actually waiting.
            if (!r1Valid) begin
                starve_cnt <= '0;
            end

            case (state)
                ST_IDLE: begin
                    if (any_valid_c) begin
                        req_q     <= winner_c ? r1_req_c : r0_req_c;
                        grantId   <= winner_c;
                        memEnable <= 1'b1;
                        state     <= ST_BUSY;
                        if (r1Valid) begin
                            if (winner_c) begin
                                starve_cnt <= '0;
                            end else if (urgent_c && (starve_cnt != CNT_MAX)) begin
                                starve_cnt <= starve_cnt + CNT_W'(1);
                            end
                        end
                    end
                end

                ST_BUSY: begin
                    if (memFinishedAction) begin
                        rdData    <= memReadData;
                        memEnable <= 1'b0;
                        r0Done    <= ~grantId;
                        r1Done    <= grantId;
                        state     <= ST_DONE;
                    end
                end

                // Valid inputs are ignored here so a requester that has just
                // seen its done pulse is not regranted on stale valid.
                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed self-checking bench for mem_port_arbiter. Expected transactions are
// queued when a request is driven and popped when the memory port presents it.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic                   clk;
    logic                   reset;
    logic                   r0Valid;
    logic                   r0Urgent;
    logic [MEM_ADDR_W-1:0]  r0Addr;
    logic                   r0Done;
    logic                   r1Valid;
    logic [MEM_ADDR_W-1:0]  r1Addr;
    logic                   r1Write;
    logic [MEM_DATA_W-1:0]  r1WData;
    logic [MEM_BYTES_W-1:0] r1Bytes;
    logic                   r1Done;
    logic [MEM_DATA_W-1:0]  rdData;
    logic [MEM_ADDR_W-1:0]  memAddr;
    logic [MEM_DATA_W-1:0]  memWriteData;
    logic                   memEnable;
    logic                   memWriteEnable;
    logic [MEM_BYTES_W-1:0] memWriteBytes;
    logic [MEM_DATA_W-1:0]  memReadData;
    logic                   memFinishedAction;
    logic                   grantId;

    int checks;
    int failures;

    typedef struct {
        logic                   id;
        logic [MEM_ADDR_W-1:0]  addr;
        logic                   we;
        logic [MEM_BYTES_W-1:0] bytes;
        logic [MEM_DATA_W-1:0]  wd;
    } exp_t;

    exp_t sb[$];

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .r0Valid           (r0Valid),
        .r0Urgent          (r0Urgent),
        .r0Addr            (r0Addr),
        .r0Done            (r0Done),
        .r1Valid           (r1Valid),
        .r1Addr            (r1Addr),
        .r1Write           (r1Write),
        .r1WData           (r1WData),
        .r1Bytes           (r1Bytes),
        .r1Done            (r1Done),
        .rdData            (rdData),
        .memAddr           (memAddr),
        .memWriteData      (memWriteData),
        .memEnable         (memEnable),
        .memWriteEnable    (memWriteEnable),
        .memWriteBytes     (memWriteBytes),
        .memReadData       (memReadData),
        .memFinishedAction (memFinishedAction),
        .grantId           (grantId)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic id, input logic [MEM_ADDR_W-1:0] addr, input logic we,
                            input logic [MEM_BYTES_W-1:0] bytes, input logic [MEM_DATA_W-1:0] wd);
        exp_t e;
        e.id = id; e.addr = addr; e.we = we; e.bytes = bytes; e.wd = wd;
        sb.push_back(e);
    endtask

    // Wait for the next memory request, compare it with the scoreboard head,
    // keep it busy for lat cycles, complete it and check the done pulse.
    // drop[i] deasserts requester i's valid in the cycle its done is seen.
    task automatic serve(input int lat, input logic [MEM_DATA_W-1:0] rd, input logic [1:0] drop);
        exp_t e;
        int   n;
        n = 0;
        while (memEnable !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (memEnable !== 1'b1) begin
            chk("mem_enable_timeout", 128'(memEnable), 128'd1);
            return;
        end
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 128'(sb.size()), 128'd1);
            return;
        end
        e = sb.pop_front();
        chk("grant_id",   128'(grantId),        128'(e.id));
        chk("mem_addr",   128'(memAddr),        128'(e.addr));
        chk("mem_we",     128'(memWriteEnable), 128'(e.we));
        chk("mem_bytes",  128'(memWriteBytes),  128'(e.bytes));
        chk("mem_wdata",  memWriteData,         e.wd);
        for (int i = 1; i < lat; i++) begin
            tick();
            chk("busy_enable", 128'(memEnable),        128'd1);
            chk("busy_addr",   128'(memAddr),          128'(e.addr));
            chk("busy_nodone", 128'({r0Done, r1Done}), 128'd0);
        end
        memReadData       = rd;
        memFinishedAction = 1'b1;
        tick();
        memFinishedAction = 1'b0;
        memReadData       = '0;
        chk("done_r0",    128'(r0Done),    128'(e.id == 1'b0));
        chk("done_r1",    128'(r1Done),    128'(e.id == 1'b1));
        chk("rd_data",    rdData,          rd);
        chk("enable_off", 128'(memEnable), 128'd0);
        if (drop[0]) begin r0Valid = 1'b0; r0Urgent = 1'b0; end
        if (drop[1]) r1Valid = 1'b0;
        tick();
        chk("done_clear", 128'({r0Done, r1Done}), 128'd0);
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        reset             = 1'b1;
        r0Valid           = 1'b0;
        r0Urgent          = 1'b0;
        r0Addr            = '0;
        r1Valid           = 1'b0;
        r1Addr            = '0;
        r1Write           = 1'b0;
        r1WData           = '0;
        r1Bytes           = '0;
        memReadData       = '0;
        memFinishedAction = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_enable", 128'(memEnable),      128'd0);
        chk("rst_we",     128'(memWriteEnable), 128'd0);
        chk("rst_bytes",  128'(memWriteBytes),  128'd0);
        chk("rst_addr",   128'(memAddr),        128'd0);
        chk("rst_wdata",  memWriteData,         128'd0);
        chk("rst_rdata",  rdData,               128'd0);
        chk("rst_dones",  128'({r0Done, r1Done}), 128'd0);
        chk("rst_grant",  128'(grantId),        128'd1);
        reset = 1'b0;
        tick();

        // Stray completion in IDLE is ignored
        memReadData       = {16{8'h5A}};
        memFinishedAction = 1'b1;
        tick();
        memFinishedAction = 1'b0;
        memReadData       = '0;
        chk("stray_dones",  128'({r0Done, r1Done}), 128'd0);
        chk("stray_enable", 128'(memEnable), 128'd0);
        chk("stray_rdata",  rdData, 128'd0);
        tick();
        chk("stray_dones2", 128'({r0Done, r1Done}), 128'd0);

        // Single r1 read: memEnable at T+1, completion at T+5, done at T+6
        r1Valid = 1'b1;
        r1Addr  = 27'h0001000;
        r1Write = 1'b0;
        push_exp(1'b1, 27'h0001000, 1'b0, 8'h00, 128'd0);
        tick();
        chk("read_enable_t1", 128'(memEnable), 128'd1);
        serve(5, {16{8'hA5}}, 2'b10);

        // Simultaneous non-urgent requests right after reset: r0 then r1
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        r0Valid = 1'b1;
        r0Addr  = 27'h0000200;
        r1Valid = 1'b1;
        r1Addr  = 27'h0000300;
        push_exp(1'b0, 27'h0000200, 1'b0, 8'h00, 128'd0);
        push_exp(1'b1, 27'h0000300, 1'b0, 8'h00, 128'd0);
        serve(3, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 2'b01);
        serve(2, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 2'b10);

        // r1 write; inputs scrambled after grant must not leak into the port
        r1Valid = 1'b1;
        r1Addr  = 27'h0ABCDE0;
        r1Write = 1'b1;
        r1Bytes = 8'h10;
        r1WData = {4{32'hDEADBEEF}};
        push_exp(1'b1, 27'h0ABCDE0, 1'b1, 8'h10, {4{32'hDEADBEEF}});
        tick();
        chk("write_enable_t1", 128'(memEnable), 128'd1);
        r1Addr  = 27'h7FFFFFF;
        r1Write = 1'b0;
        r1Bytes = 8'hFF;
        r1WData = '1;
        serve(4, 128'd0, 2'b10);
        r1Write = 1'b0;
        r1Bytes = '0;
        r1WData = '0;

        // Following r0 read clears the write fields
        r0Valid = 1'b1;
        r0Addr  = 27'h0123450;
        push_exp(1'b0, 27'h0123450, 1'b0, 8'h00, 128'd0);
        serve(3, {8{16'hC0DE}}, 2'b01);

        // r1 arriving while r0 is busy waits and is served next
        r0Valid = 1'b1;
        r0Addr  = 27'h0000400;
        push_exp(1'b0, 27'h0000400, 1'b0, 8'h00, 128'd0);
        tick();
        r1Valid = 1'b1;
        r1Addr  = 27'h0000500;
        push_exp(1'b1, 27'h0000500, 1'b0, 8'h00, 128'd0);
        serve(4, {4{32'h0BADF00D}}, 2'b01);
        serve(2, {4{32'hFACEB00C}}, 2'b10);

        // Urgent r0 against waiting r1: grant order 0,0,0,0,1,0
        r0Valid  = 1'b1;
        r0Urgent = 1'b1;
        r0Addr   = 27'h0000010;
        r1Valid  = 1'b1;
        r1Addr   = 27'h0000020;
        push_exp(1'b0, 27'h0000010, 1'b0, 8'h00, 128'd0);
        push_exp(1'b0, 27'h0000010, 1'b0, 8'h00, 128'd0);
        push_exp(1'b0, 27'h0000010, 1'b0, 8'h00, 128'd0);
        push_exp(1'b0, 27'h0000010, 1'b0, 8'h00, 128'd0);
        push_exp(1'b1, 27'h0000020, 1'b0, 8'h00, 128'd0);
        push_exp(1'b0, 27'h0000010, 1'b0, 8'h00, 128'd0);
        for (int k = 0; k < 5; k++) begin
            serve(2, 128'(k + 1), 2'b00);
        end
        serve(2, 128'd6, 2'b11);

        // Reset two cycles after memEnable rises aborts with no done pulse
        r0Valid = 1'b1;
        r0Addr  = 27'h0000055;
        tick();
        chk("abort_enable_t1", 128'(memEnable), 128'd1);
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("abort_enable", 128'(memEnable), 128'd0);
        chk("abort_addr",   128'(memAddr),   128'd0);
        chk("abort_grant",  128'(grantId),   128'd1);
        chk("abort_dones",  128'({r0Done, r1Done}), 128'd0);
        r0Valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("post_abort_dones",  128'({r0Done, r1Done}), 128'd0);
        chk("post_abort_enable", 128'(memEnable), 128'd0);
        tick();
        chk("post_abort_dones2", 128'({r0Done, r1Done}), 128'd0);

        // Reissued request after reset is serviced normally
        r0Valid = 1'b1;
        r0Addr  = 27'h0000066;
        push_exp(1'b0, 27'h0000066, 1'b0, 8'h00, 128'd0);
        tick();
        chk("reissue_enable_t1", 128'(memEnable), 128'd1);
        serve(3, {16{8'h3C}}, 2'b01);

        chk("scoreboard_drained", 128'(sb.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: number of consecutive urgent requester-0 grants allowed while requester 1 is waiting.
REQ-002 SHALL have port clk, input, 1: single clock; all logic is on the rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port r0Valid, input, 1: scanout read request, held until r0Done.
REQ-005 SHALL have port r0Urgent, input, 1: scanout line buffer is near empty.
REQ-006 SHALL have port r0Addr, input, 27: scanout read address.
REQ-007 SHALL have port r0Done, output, 1: one-cycle completion pulse for requester 0.
REQ-008 SHALL have ports r1Valid (input, 1), r1Addr (input, 27), r1Write (input, 1), r1WData (input, 128) and r1Bytes (input, 8): the GPU cache request, held until r1Done.
REQ-009 SHALL have port r1Done, output, 1: one-cycle completion pulse for requester 1.
REQ-010 SHALL have port rdData, output, 128: read data, valid in the cycle r0Done or r1Done is high.
REQ-011 SHALL have ports memAddr (output, 27), memWriteData (output, 128), memEnable (output, 1), memWriteEnable (output, 1) and memWriteBytes (output, 8): the global memory request.
REQ-012 SHALL have ports memReadData (input, 128) and memFinishedAction (input, 1): the global memory response; memFinishedAction is a one-cycle completion pulse.
REQ-013 SHALL have port grantId, output, 1: owner of the current or most recent transaction (0 or 1).

Function
REQ-014 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-015 In IDLE with any valid request, SHALL pick a winner, latch its fields into the mem* registers, assert memEnable on the next cycle and enter BUSY.
REQ-016 Arbitration SHALL follow these rules in order: r0Urgent&r0Valid wins unless the starvation counter equals STARVE_LIMIT and r1Valid is high; otherwise round-robin, where the requester not last granted wins a tie.
REQ-017 The starvation counter SHALL increment on each urgent r0 grant while r1Valid is high, clear on any r1 grant or when r1Valid is low, and saturate at STARVE_LIMIT.
REQ-018 A requester-0 transaction SHALL force memWriteEnable=0, memWriteBytes=0 and memWriteData=0.
REQ-019 In BUSY, memEnable and all mem* outputs SHALL hold stable until memFinishedAction=1.
REQ-020 When memFinishedAction=1 in BUSY, SHALL capture memReadData into rdData, drop memEnable the next cycle and enter DONE.
REQ-021 In DONE, SHALL pulse exactly one of r0Done or r1Done for the granted requester, ignore all valid inputs, and return to IDLE.
REQ-022 Latency: request seen in IDLE at cycle T -> memEnable=1 at T+1; memFinishedAction at cycle F -> done pulse at F+1 -> IDLE at F+2.
REQ-023 SHALL ignore memFinishedAction in IDLE and DONE.
REQ-024 A request arriving during BUSY or DONE SHALL wait without being dropped.
REQ-025 Requesters deassert valid in the cycle they observe done, so a back-to-back request from the same requester SHALL be seen at the earliest in the IDLE cycle after DONE.
REQ-026 r*Addr and r1 write fields SHALL NOT affect an in-flight transaction after grant.

Reset
REQ-027 Reset SHALL immediately (asynchronously) force state=IDLE, memEnable=0, memWriteEnable=0, memWriteBytes=0, memAddr=0, memWriteData=0, rdData=0, r0Done=0, r1Done=0, grantId=1 (so requester 0 wins the first tie), and starvation counter=0.
REQ-028 Reset asserted mid-transaction SHALL abort the transaction with no done pulse; requesters reissue after reset.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, MEM_ADDR_W=27, MEM_DATA_W=128, MEM_BYTES_W=8 and the default STARVE_LIMIT.
REQ-030 SHALL contain a single sub-module, rr_grant2: a combinational 2-way arbiter taking urgent, starved and lastGrant, and producing the winner.
REQ-031 The FSM and datapath registers SHALL live in mem_port_arbiter.

Verification
REQ-032 Single read: r1Valid, r1Addr=0x0001000, r1Write=0; memFinishedAction at T+5 with memReadData=0xA5..A5 -> memEnable high T+1..T+5, r1Done and rdData=0xA5..A5 at T+6.
REQ-033 Simultaneous non-urgent r0 and r1 after reset -> r0 served first, then r1; grantId sequence 0,1.
REQ-034 r0Urgent held with r1Valid held, STARVE_LIMIT=4 -> grant order 0,0,0,0,1,0,...
REQ-035 r1 write with r1Bytes=0x10 and r1WData=0xDEADBEEF.. -> memWriteEnable=1, memWriteBytes=0x10, memWriteData matches; a subsequent r0 read shows memWriteEnable=0.
REQ-036 Reset asserted 2 cycles after memEnable rises -> memEnable=0 in the same cycle, no done pulse, next request serviced normally.
REQ-037 Stray memFinishedAction in IDLE -> no done pulse and no state change.
